// File: rtl/mul_arb.sv
// Round-robin arbiter/sequencer sharing one signed 16x16 multiplier between two requesters.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
module mul_arb #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_err,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_err,
   output logic        mul_start,
   output logic [3:0]  mul_dtype,
   output logic [15:0] mul_m,
   output logic [15:0] mul_q,
   input  logic        mul_done,
   input  logic [31:0] mul_result,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        last_grant;
   logic        owner;
   logic        err;
   logic [15:0] op_m;
   logic [15:0] op_q;
   logic [31:0] res;
   logic [7:0]  wd;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        rsp_fire;
   logic        wd_expired;

   // On a tie the requester that was not served last wins; grants are mutually exclusive.
   assign grant0     = req0_valid && (!req1_valid || last_grant);
   assign grant1     = req1_valid && (!req0_valid || !last_grant);
   assign accept     = (state == IDLE) && !rst && (grant0 || grant1);
   assign rsp_fire   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
   assign wd_expired = (wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = BUSY;
         BUSY:    if (mul_done || wd_expired) state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_m       <= '0;
         op_q       <= '0;
         res        <= '0;
         err        <= 1'b0;
         wd         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= !grant0;
                  last_grant <= !grant0;
                  op_m       <= grant0 ? req0_a : req1_a;
                  op_q       <= grant0 ? req0_b : req1_b;
               end
            end
            LAUNCH: wd <= '0;
            BUSY: begin
               wd <= wd + 8'd1;
               // A done in the final watchdog cycle still delivers the product.
               if (mul_done) begin
                  res <= mul_result;
                  err <= 1'b0;
               end else if (wd_expired) begin
                  res <= '0;
                  err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req0_ready  = (state == IDLE) && !rst && grant0;
      req1_ready  = (state == IDLE) && !rst && grant1;
      rsp0_valid  = (state == RESP) && !owner;
      rsp1_valid  = (state == RESP) && owner;
      rsp0_result = rsp0_valid ? res : 32'd0;
      rsp1_result = rsp1_valid ? res : 32'd0;
      rsp0_err    = rsp0_valid && err;
      rsp1_err    = rsp1_valid && err;
      mul_start   = (state == LAUNCH);
      mul_dtype   = (state == LAUNCH) ? 4'h1 : 4'h0;
      // The multiplier samples M/Q every cycle, so they stay driven through BUSY.
      mul_m       = ((state == LAUNCH) || (state == BUSY)) ? op_m : 16'd0;
      mul_q       = ((state == LAUNCH) || (state == BUSY)) ? op_q : 16'd0;
      busy        = (state != IDLE);
      dbg_state   = state;
   end

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: vector table, hand-written corner sequences and random traffic
// against a transaction-level reference model with a behavioural multiplier.
module tb_mul_arb;

   localparam int TIMEOUT = 32;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          d;   // cycles from start to done; 0 means the multiplier never answers
   } op_t;

   typedef struct {
      int          who;
      logic [15:0] a;
      logic [15:0] b;
      int          d;
      logic [31:0] res;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [15:0] req0_a = '0;
   logic [15:0] req0_b = '0;
   logic        rsp0_valid;
   logic        rsp0_ready = 1'b1;
   logic [31:0] rsp0_result;
   logic        rsp0_err;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [15:0] req1_a = '0;
   logic [15:0] req1_b = '0;
   logic        rsp1_valid;
   logic        rsp1_ready = 1'b1;
   logic [31:0] rsp1_result;
   logic        rsp1_err;
   logic        mul_start;
   logic [3:0]  mul_dtype;
   logic [15:0] mul_m;
   logic [15:0] mul_q;
   logic        mul_done = 1'b0;
   logic [31:0] mul_result = '0;
   logic        busy;
   logic [1:0]  dbg_state;

   mul_arb #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
      .mul_start(mul_start), .mul_dtype(mul_dtype), .mul_m(mul_m), .mul_q(mul_q),
      .mul_done(mul_done), .mul_result(mul_result), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   op_t         src0_q[$];
   op_t         src1_q[$];
   int          grant_log[$];
   logic [31:0] res_log[$];
   logic        outst = 1'b0;
   logic        launch_due = 1'b0;
   int          exp_last = 1;
   int          cur_own = 0;
   logic [15:0] cur_a = '0;
   logic [15:0] cur_b = '0;
   int          cur_d = 0;
   logic [31:0] cur_res = '0;
   logic        cur_err = 1'b0;
   int          cur_lat = 0;
   int          acc_cyc = 0;
   int          hs_cyc = -1000;
   int          last_gap = 0;
   int          last_own = -1;
   logic [31:0] last_res = '0;
   logic        last_err = 1'b0;
   int          acc_count = 0;
   int          hs_count = 0;
   int          rdy0_mode = 0;   // 0: always ready, 1: random, 2: stalled
   int          rdy1_mode = 0;
   int          mcnt = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int p;
      p = $signed(a) * $signed(b);
      return p;
   endfunction

   // ---------------- behavioural multiplier ----------------
   always @(negedge clk) begin
      mul_done   = 1'b0;
      mul_result = $urandom;
      if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            mul_done   = 1'b1;
            mul_result = ref_mul(mul_m, mul_q);
         end
      end
      if (mul_start) mcnt = cur_d;
   end

   // ---------------- requester / responder drivers ----------------
   always @(posedge clk) begin
      #1;
      if (src0_q.size() > 0) begin
         req0_valid = 1'b1; req0_a = src0_q[0].a; req0_b = src0_q[0].b;
      end else begin
         req0_valid = 1'b0; req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (src1_q.size() > 0) begin
         req1_valid = 1'b1; req1_a = src1_q[0].a; req1_b = src1_q[0].b;
      end else begin
         req1_valid = 1'b0; req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      rsp0_ready = (rdy0_mode == 0) ? 1'b1 : (rdy0_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rsp1_ready = (rdy1_mode == 0) ? 1'b1 : (rdy1_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // ---------------- transaction-level reference model and monitor ----------------
   always @(negedge clk) begin
      logic       outst0;
      logic       ev;
      logic       hs;
      logic [1:0] exp_rdy;
      int         w;
      op_t        e;
      cyc++;
      if (rst) begin
         outst      = 1'b0;
         launch_due = 1'b0;
         exp_last   = 1;
      end else begin
         outst0 = outst;
         hs     = 1'b0;
         chk("busy", busy, outst0);
         chk("mul_start", mul_start, launch_due);
         chk("mul_dtype", mul_dtype, launch_due ? 32'd1 : 32'd0);
         if (launch_due) begin
            chk("mul_m", mul_m, cur_a);
            chk("mul_q", mul_q, cur_b);
         end
         launch_due = 1'b0;

         ev = outst0 && (cur_own == 0) && (cyc - acc_cyc >= cur_lat);
         chk("rsp0_valid", rsp0_valid, ev);
         if (ev && rsp0_valid) begin
            chk("rsp0_result", rsp0_result, cur_res);
            chk("rsp0_err", rsp0_err, cur_err);
            if (rsp0_ready) begin hs = 1'b1; last_res = rsp0_result; last_err = rsp0_err; end
         end
         ev = outst0 && (cur_own == 1) && (cyc - acc_cyc >= cur_lat);
         chk("rsp1_valid", rsp1_valid, ev);
         if (ev && rsp1_valid) begin
            chk("rsp1_result", rsp1_result, cur_res);
            chk("rsp1_err", rsp1_err, cur_err);
            if (rsp1_ready) begin hs = 1'b1; last_res = rsp1_result; last_err = rsp1_err; end
         end
         if (hs) begin
            outst    = 1'b0;
            hs_cyc   = cyc;
            last_own = cur_own;
            hs_count++;
            res_log.push_back(last_res);
         end

         // Arbitration rule: nothing while an op is outstanding; lone valid wins; ties alternate.
         if (outst0) exp_rdy = 2'b00;
         else if (req0_valid && req1_valid) exp_rdy = (exp_last == 1) ? 2'b01 : 2'b10;
         else exp_rdy = {req1_valid, req0_valid};
         chk("req_ready", {req1_ready, req0_ready}, exp_rdy);

         w = -1;
         if (req0_valid && req0_ready) w = 0;
         else if (req1_valid && req1_ready) w = 1;
         if (w >= 0) begin
            e = '{a: 16'h0, b: 16'h0, d: 0};
            if (w == 0 && src0_q.size() > 0) e = src0_q.pop_front();
            else if (w == 1 && src1_q.size() > 0) e = src1_q.pop_front();
            cur_own    = w;
            cur_a      = e.a;
            cur_b      = e.b;
            cur_d      = e.d;
            cur_err    = !(e.d > 0 && e.d <= TIMEOUT);
            cur_res    = cur_err ? 32'd0 : ref_mul(e.a, e.b);
            cur_lat    = cur_err ? TIMEOUT + 2 : e.d + 2;
            acc_cyc    = cyc;
            last_gap   = cyc - hs_cyc;
            exp_last   = w;
            outst      = 1'b1;
            launch_due = 1'b1;
            acc_count++;
            grant_log.push_back(w);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic push_op(input int who, input logic [15:0] a, input logic [15:0] b, input int d);
      op_t o;
      o = '{a: a, b: b, d: d};
      if (who == 0) src0_q.push_back(o);
      else src1_q.push_back(o);
   endtask

   task automatic wait_drain(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         if (src0_q.size() == 0 && src1_q.size() == 0 && !outst) break;
      end
      chk("drain_in_budget", 32'(i < budget), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req0_ready"}, req0_ready, 0);
      chk({tag, "_req1_ready"}, req1_ready, 0);
      chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
      chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
      chk({tag, "_rsp0_result"}, rsp0_result, 0);
      chk({tag, "_rsp1_result"}, rsp1_result, 0);
      chk({tag, "_rsp0_err"}, rsp0_err, 0);
      chk({tag, "_rsp1_err"}, rsp1_err, 0);
      chk({tag, "_mul_start"}, mul_start, 0);
      chk({tag, "_mul_dtype"}, mul_dtype, 0);
      chk({tag, "_mul_m"}, mul_m, 0);
      chk({tag, "_mul_q"}, mul_q, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_state"}, dbg_state, 0);
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[8];

   initial begin
      int hs0;
      int acc0;
      int i;
      vecs[0] = '{who: 0, a: 16'h0003, b: 16'hFFFE, d: 18, res: 32'hFFFF_FFFA, err: 1'b0};
      vecs[1] = '{who: 1, a: 16'hFFFF, b: 16'hFFFF, d: 18, res: 32'h0000_0001, err: 1'b0};
      vecs[2] = '{who: 0, a: 16'h8000, b: 16'h8000, d: 18, res: 32'h4000_0000, err: 1'b0};
      vecs[3] = '{who: 1, a: 16'h8000, b: 16'h7FFF, d: 5, res: 32'hC000_8000, err: 1'b0};
      vecs[4] = '{who: 0, a: 16'h0000, b: 16'h1234, d: 1, res: 32'h0000_0000, err: 1'b0};
      vecs[5] = '{who: 1, a: 16'hFFFF, b: 16'h0001, d: TIMEOUT, res: 32'hFFFF_FFFF, err: 1'b0};
      vecs[6] = '{who: 0, a: 16'h1234, b: 16'h5678, d: TIMEOUT + 1, res: 32'h0, err: 1'b1};
      vecs[7] = '{who: 1, a: 16'h7FFF, b: 16'h7FFF, d: 0, res: 32'h0, err: 1'b1};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Vector table: single ops, done on the last watchdog cycle, timeouts
      foreach (vecs[k]) begin
         push_op(vecs[k].who, vecs[k].a, vecs[k].b, vecs[k].d);
         wait_drain(TIMEOUT + 30);
         chk($sformatf("vec%0d_owner", k), last_own, vecs[k].who);
         chk($sformatf("vec%0d_result", k), last_res, vecs[k].res);
         chk($sformatf("vec%0d_err", k), last_err, vecs[k].err);
      end

      // Contention straight out of reset: req0 wins the first tie
      rst = 1'b1;
      grant_log.delete();
      res_log.delete();
      push_op(0, 16'h7FFF, 16'h7FFF, 18);
      push_op(1, 16'hFFFF, 16'hFFFF, 18);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_drain(200);
      chk("contend_n", grant_log.size(), 2);
      chk("contend_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
      chk("contend_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
      chk("contend_res0", (res_log.size() > 0) ? res_log[0] : 32'hDEAD_BEEF, 32'h3FFF_0001);
      chk("contend_res1", (res_log.size() > 1) ? res_log[1] : 32'hDEAD_BEEF, 32'h0000_0001);

      // Fairness: both continuously valid for six ops
      grant_log.delete();
      for (i = 0; i < 3; i++) begin
         push_op(0, 16'($urandom), 16'($urandom), 18);
         push_op(1, 16'($urandom), 16'($urandom), 18);
      end
      wait_drain(400);
      for (i = 0; i < 6; i++)
         chk($sformatf("fair_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, i % 2);

      // Back-pressure on requester 1 for 50 cycles with req0 waiting
      rdy1_mode = 2;
      res_log.delete();
      push_op(1, 16'h1111, 16'h2222, 18);
      for (i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (rsp1_valid) break;
      end
      chk("bp_rsp1_seen", 32'(i < 60), 32'd1);
      acc0 = acc_count;
      push_op(0, 16'h0005, 16'h0006, 10);
      repeat (50) @(posedge clk);
      #1;
      chk("bp_no_accept", acc_count, acc0);
      chk("bp_still_valid", rsp1_valid, 1);
      chk("bp_result_held", rsp1_result, 32'h0246_8642);
      rdy1_mode = 0;
      wait_drain(100);
      chk("bp_res1", (res_log.size() > 0) ? res_log[0] : 32'hDEAD_BEEF, 32'h0246_8642);
      chk("bp_bubble", last_gap, 1);
      chk("bp_next_owner", last_own, 0);
      chk("bp_next_result", last_res, 32'h0000_001E);

      // Reset in the middle of BUSY; the multiplier's late done must be ignored
      acc0 = acc_count;
      hs0  = hs_count;
      push_op(0, 16'h1234, 16'h5678, 18);
      for (i = 0; i < 20; i++) begin
         @(posedge clk);
         if (acc_count != acc0) break;
      end
      chk("midrst_accepted", 32'(i < 20), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_outputs("midrst");
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_rsp", hs_count, hs0);
      chk("midrst_idle", busy, 0);
      push_op(0, 16'hFFF0, 16'h0010, 18);
      wait_drain(100);
      chk("midrst_next_result", last_res, 32'hFFFF_FF00);
      chk("midrst_next_err", last_err, 0);

      // Randomised traffic with random back-pressure and multiplier latency
      rdy0_mode = 1;
      rdy1_mode = 1;
      hs0 = hs_count;
      for (i = 0; i < 40; i++)
         push_op($urandom_range(0, 1), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2));
      wait_drain(6000);
      chk("rand_all_done", hs_count - hs0, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
